// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        LOAD = 2'd2
    } state_t;

    localparam int DIGIT_W = 4;
    localparam logic [3:0] BCD_FIX_THRESH = 4'd5;
    localparam logic [3:0] BCD_FIX_ADD    = 4'd3;

endpackage

// File: rtl/bin2bcd_digits_if.sv
// Handshake and result bundle between a value source and the BCD converter.
interface bin2bcd_digits_if #(
    parameter int IN_W   = 16,
    parameter int DIGITS = 6
);
    logic                  in_valid;
    logic                  in_ready;
    logic [IN_W-1:0]       in_value;
    logic                  blank_en;
    logic [4*DIGITS-1:0]   digits;
    logic [DIGITS-1:0]     digit_blank;
    logic                  overflow;
    logic                  done;

    // Source side: offers values and chooses blanking, observes results.
    modport master (
        output in_valid, in_value, blank_en,
        input  in_ready, digits, digit_blank, overflow, done
    );

    // Converter side.
    modport slave (
        input  in_valid, in_value, blank_en,
        output in_ready, digits, digit_blank, overflow, done
    );
endinterface

// File: rtl/bin2bcd_digits_add3.sv
// Single-digit shift-and-add-3 correction: digits of 5 or more get +3 so the
// following left shift carries correctly into the next decimal digit.
module bcd_add3_digit
    import bin2bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_d,
    output logic [DIGIT_W-1:0] o_d
);
    assign o_d = (i_d >= BCD_FIX_THRESH) ? (i_d + BCD_FIX_ADD) : i_d;
endmodule

// File: rtl/bin2bcd_digits.sv
// Sequential binary-to-BCD converter, one input bit per clock, with a
// leading-zero blank mask and a sticky overflow flag for out-of-range values.
module bin2bcd_digits
    import bin2bcd_pkg::*;
#(
    parameter int IN_W   = 16,
    parameter int DIGITS = 6
) (
    input  logic             clk,
    input  logic             reset,
    bin2bcd_digits_if.slave  bus
);
    localparam int CNT_W = $clog2(IN_W + 1);
    localparam int ACC_W = DIGIT_W * DIGITS;

    state_t              r_state;
    state_t              w_state_next;
    logic [IN_W-1:0]     r_shift;
    logic [ACC_W-1:0]    r_acc;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_ovf_sticky;
    logic [ACC_W-1:0]    r_digits;
    logic                r_overflow;
    logic                r_done;

    logic                w_accept;
    logic                w_last_shift;
    logic [ACC_W-1:0]    w_fixed;
    logic [ACC_W-1:0]    w_acc_shifted;
    logic [DIGITS-1:0]   w_blank;

    assign w_accept     = bus.in_valid && (r_state == IDLE);
    assign w_last_shift = (r_cnt == CNT_W'(IN_W - 1));

    // Every digit is corrected in parallel before the shift.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_fix
            bcd_add3_digit u_fix (
                .i_d (r_acc[gi*DIGIT_W +: DIGIT_W]),
                .o_d (w_fixed[gi*DIGIT_W +: DIGIT_W])
            );
        end
    endgenerate

    // Corrected accumulator shifted left, next binary bit entering at bit 0.
    assign w_acc_shifted = {w_fixed[ACC_W-2:0], r_shift[IN_W-1]};

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state logic: accept, shift IN_W times, then publish once.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (bus.in_valid) w_state_next = CONV;
            CONV:    if (w_last_shift) w_state_next = LOAD;
            LOAD:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Datapath: shift register, accumulator, bit counter and result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift      <= '0;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_ovf_sticky <= 1'b0;
            r_digits     <= '0;
            r_overflow   <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= (r_state == LOAD);
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_shift      <= bus.in_value;
                        r_acc        <= '0;
                        r_cnt        <= '0;
                        r_ovf_sticky <= 1'b0;
                    end
                end
                CONV: begin
                    r_acc        <= w_acc_shifted;
                    // A 1 leaving the top digit means the value needs more digits.
                    r_ovf_sticky <= r_ovf_sticky | w_fixed[ACC_W-1];
                    r_shift      <= r_shift << 1;
                    r_cnt        <= r_cnt + 1'b1;
                end
                LOAD: begin
                    r_digits   <= r_acc;
                    r_overflow <= r_ovf_sticky;
                end
                default: ;
            endcase
        end
    end

    // Blank display i when blanking is on and it and all higher digits are zero;
    // the least significant digit always stays visible.
    always_comb begin
        logic w_upper_zero;
        w_blank      = '0;
        w_upper_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            w_upper_zero = w_upper_zero && (r_digits[i*DIGIT_W +: DIGIT_W] == '0);
            w_blank[i]   = bus.blank_en && w_upper_zero;
        end
    end

    assign bus.in_ready    = (r_state == IDLE);
    assign bus.digits      = r_digits;
    assign bus.overflow    = r_overflow;
    assign bus.done        = r_done;
    assign bus.digit_blank = w_blank;

endmodule

// File: tb/tb_bin2bcd_digits.sv
// Bench for bin2bcd_digits: a 16-bit and a 20-bit instance, vector table,
// hand-written handshake/reset sequences and random values vs. a decimal model.
module tb_bin2bcd_digits;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    bin2bcd_digits_if #(.IN_W(16), .DIGITS(6)) a_if ();
    bin2bcd_digits_if #(.IN_W(20), .DIGITS(6)) b_if ();

    bin2bcd_digits #(.IN_W(16), .DIGITS(6)) u_a (.clk(clk), .reset(reset), .bus(a_if));
    bin2bcd_digits #(.IN_W(20), .DIGITS(6)) u_b (.clk(clk), .reset(reset), .bus(b_if));

    typedef struct {
        bit          sel;      // 0: 16-bit instance, 1: 20-bit instance
        logic [19:0] value;
        logic        be;
        logic [23:0] exp_digits;
        logic [5:0]  exp_blank;
        logic        exp_ovf;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic get_ready(input bit sel);
        return sel ? b_if.in_ready : a_if.in_ready;
    endfunction
    function automatic logic get_done(input bit sel);
        return sel ? b_if.done : a_if.done;
    endfunction
    function automatic logic [23:0] get_digits(input bit sel);
        return sel ? b_if.digits : a_if.digits;
    endfunction
    function automatic logic get_ovf(input bit sel);
        return sel ? b_if.overflow : a_if.overflow;
    endfunction
    function automatic logic [5:0] get_blank(input bit sel);
        return sel ? b_if.digit_blank : a_if.digit_blank;
    endfunction

    task automatic drive(input bit sel, input logic v, input logic [19:0] val, input logic be);
        if (sel) begin
            b_if.in_valid = v; b_if.in_value = val; b_if.blank_en = be;
        end else begin
            a_if.in_valid = v; a_if.in_value = val[15:0]; a_if.blank_en = be;
        end
    endtask

    // Decimal reference: plain division into digits, modulo 10^6.
    function automatic void model(input int unsigned v, input logic be,
                                  output logic [23:0] d, output logic ovf,
                                  output logic [5:0] bl);
        int unsigned r;
        bit z;
        ovf = (v > 999999);
        r = v % 1000000;
        d = '0;
        for (int i = 0; i < 6; i++) begin
            d[4*i +: 4] = 4'(r % 10);
            r = r / 10;
        end
        bl = '0;
        for (int i = 1; i < 6; i++) begin
            z = 1'b1;
            for (int j = i; j < 6; j++) if (d[4*j +: 4] != 4'd0) z = 1'b0;
            bl[i] = be & z;
        end
    endfunction

    // One full conversion with latency, busy-window and single-pulse checks.
    task automatic run_conv(input bit sel, input logic [19:0] v, input logic be,
                            output logic [23:0] d, output logic ovf, output logic [5:0] bl);
        int k;
        int busy;
        int inw;
        inw = sel ? 20 : 16;
        @(negedge clk);
        check("ready_before_accept", 32'(get_ready(sel)), 32'd1);
        drive(sel, 1'b1, v, be);
        @(posedge clk);
        @(negedge clk);
        drive(sel, 1'b0, v, be);
        k = 0;
        busy = 0;
        while (!get_done(sel) && k < 40) begin
            if (!get_ready(sel)) busy++;
            @(negedge clk);
            k++;
        end
        check("done_latency", 32'(k), 32'(inw + 1));
        check("ready_low_cycles", 32'(busy), 32'(inw + 1));
        d   = get_digits(sel);
        ovf = get_ovf(sel);
        bl  = get_blank(sel);
        $display("conv dut=%0d value=%0d digits=%h ovf=%b blank=%b latency=%0d",
                 sel, v, d, ovf, bl, k);
        @(negedge clk);
        check("done_one_cycle", 32'(get_done(sel)), 32'd0);
    endtask

    initial begin
        vec_t        vecs[6];
        logic [23:0] d, ed;
        logic        ovf, eovf;
        logic [5:0]  bl, ebl;
        int          k;
        bit          saw_done;
        int unsigned rv;

        vecs[0] = '{1'b0, 20'd0,       1'b1, 24'h000000, 6'b111110, 1'b0};
        vecs[1] = '{1'b0, 20'd65535,   1'b1, 24'h065535, 6'b100000, 1'b0};
        vecs[2] = '{1'b0, 20'd1234,    1'b0, 24'h001234, 6'b000000, 1'b0};
        vecs[3] = '{1'b1, 20'd999999,  1'b1, 24'h999999, 6'b000000, 1'b0};
        vecs[4] = '{1'b1, 20'd1000000, 1'b1, 24'h000000, 6'b111110, 1'b1};
        vecs[5] = '{1'b1, 20'd1048575, 1'b1, 24'h048575, 6'b100000, 1'b1};

        drive(1'b0, 1'b0, 20'd0, 1'b0);
        drive(1'b1, 1'b0, 20'd0, 1'b0);

        // Reset state.
        repeat (2) @(negedge clk);
        check("reset_ready",    32'(a_if.in_ready), 32'd1);
        check("reset_digits",   32'(a_if.digits),   32'd0);
        check("reset_overflow", 32'(a_if.overflow), 32'd0);
        check("reset_done",     32'(a_if.done),     32'd0);
        reset = 1'b0;

        // Vector table.
        for (int i = 0; i < 6; i++) begin
            run_conv(vecs[i].sel, vecs[i].value, vecs[i].be, d, ovf, bl);
            check($sformatf("vec%0d_digits", i),   32'(d),   32'(vecs[i].exp_digits));
            check($sformatf("vec%0d_blank", i),    32'(bl),  32'(vecs[i].exp_blank));
            check($sformatf("vec%0d_overflow", i), 32'(ovf), 32'(vecs[i].exp_ovf));
            // After the 1234 conversion, turning blanking on acts immediately.
            if (i == 2) begin
                a_if.blank_en = 1'b1;
                #1;
                check("blank_toggle_mask",   32'(a_if.digit_blank), 32'h30);
                check("blank_toggle_digits", 32'(a_if.digits),      32'h001234);
            end
        end

        // in_valid held high, value changed while busy.
        @(negedge clk);
        drive(1'b0, 1'b1, 20'd9, 1'b0);
        @(posedge clk);
        @(negedge clk);
        a_if.in_value = 16'd10;
        k = 0;
        while (!a_if.done && k < 40) begin @(negedge clk); k++; end
        check("held_first_latency", 32'(k), 32'd17);
        check("held_first_digits",  32'(a_if.digits), 32'h000009);
        $display("conv dut=0 value=9 digits=%h ovf=%b blank=%b latency=%0d",
                 a_if.digits, a_if.overflow, a_if.digit_blank, k);
        @(negedge clk);
        check("held_second_accept_e18", 32'(a_if.in_ready), 32'd0);
        a_if.in_valid = 1'b0;
        k = 0;
        while (!a_if.done && k < 40) begin @(negedge clk); k++; end
        check("held_second_latency", 32'(k), 32'd17);
        check("held_second_digits",  32'(a_if.digits), 32'h000010);
        $display("conv dut=0 value=10 digits=%h ovf=%b blank=%b latency=%0d",
                 a_if.digits, a_if.overflow, a_if.digit_blank, k);

        // Reset in the middle of a conversion.
        @(negedge clk);
        drive(1'b0, 1'b1, 20'd40000, 1'b0);
        @(posedge clk);
        @(negedge clk);
        a_if.in_valid = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midreset_ready",    32'(a_if.in_ready), 32'd1);
        check("midreset_digits",   32'(a_if.digits),   32'd0);
        check("midreset_overflow", 32'(a_if.overflow), 32'd0);
        check("midreset_b_ovf",    32'(b_if.overflow), 32'd0);
        repeat (2) @(negedge clk);
        check("midreset_ready_held", 32'(a_if.in_ready), 32'd1);
        reset = 1'b0;
        saw_done = 1'b0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (a_if.done) saw_done = 1'b1;
        end
        check("midreset_no_done", 32'(saw_done), 32'd0);
        $display("conv dut=0 value=40000 aborted by reset");
        run_conv(1'b0, 20'd7, 1'b0, d, ovf, bl);
        check("after_reset_digits", 32'(d), 32'h000007);

        // Random values on both widths against the decimal model.
        for (int i = 0; i < 24; i++) begin
            bit sel;
            logic be;
            sel = bit'(i % 2);
            be  = logic'($urandom_range(0, 1));
            rv  = sel ? $urandom_range(0, 1048575) : $urandom_range(0, 65535);
            run_conv(sel, 20'(rv), be, d, ovf, bl);
            model(rv, be, ed, eovf, ebl);
            check($sformatf("rand%0d_digits", i),   32'(d),   32'(ed));
            check($sformatf("rand%0d_overflow", i), 32'(ovf), 32'(eovf));
            check($sformatf("rand%0d_blank", i),    32'(bl),  32'(ebl));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bin2bcd_digits.md
Name: bin2bcd_digits

Overview:
- Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock). Sits directly upstream of the hex7seg seven-segment decoders.
- Accepts a binary value, such as a Collatz step count or current term, over a valid/ready handshake.
- Produces one 4-bit decimal digit per display position, plus a leading-zero blank mask and overflow flag. Top level instantiates one hex7seg per digit and forces the segments to 7'b1111111 where the blank bit is set.

Parameters:
- IN_W, 16, width of the binary input.
- DIGITS, 6, number of BCD output digits (HEX0..HEX5).

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous, active-high reset.
- in_valid, input, 1, in_value is presented.
- in_ready, output, 1, block can accept a value.
- in_value, input, IN_W, unsigned binary value to convert.
- blank_en, input, 1, enables leading-zero blanking.
- digits, output, 4*DIGITS, BCD digits; digit i at [4i+3:4i], digit 0 is least significant.
- digit_blank, output, DIGITS, bit i set means display i is blanked.
- overflow, output, 1, value from the last conversion exceeded 10^DIGITS-1.
- done, output, 1, one-cycle pulse when digits/overflow update.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-high.
- Reset values: state IDLE, digits = 0, overflow = 0, done = 0, in_ready = 1 (held high during and after reset). Internal shift register, BCD accumulator and bit counter are cleared.
- in_ready: combinational, equal to (state == IDLE).
- IDLE:
  - Acceptance occurs at the rising edge where in_valid & in_ready (call it E0).
  - At E0: load in_value into the shift register, clear the BCD accumulator and sticky overflow, set count = 0, go to CONV.
- CONV (edges E1..E_IN_W):
  - Each cycle, every accumulator digit >= 5 gets +3 (all digits corrected in parallel).
  - The accumulator then shifts left 1, taking the shift register MSB into bit 0. The shift register also shifts left 1.
  - Any 1 shifted out of the top digit sets sticky overflow.
  - At the edge performing the IN_W-th shift, go to LOAD.
- LOAD (edge E_IN_W+1): register accumulator into digits and sticky flag into overflow; assert done for exactly one cycle; go to IDLE.
- Timing: done is visible IN_W+1 cycles after the accept edge. The next accept is no earlier than edge E_IN_W+2.
- Holding and ignored inputs:
  - digits and overflow hold their value between conversions; only LOAD changes them.
  - in_value and in_valid are ignored while busy; no queuing.
- Overflow: if overflow = 1, digits hold the low DIGITS decimal digits of the value (modulo 10^DIGITS).
- digit_blank: combinational from registered digits and blank_en. Bit i (i >= 1) is set iff blank_en = 1 and digits i..DIGITS-1 are all zero. Bit 0 is never set.
- Reset mid-conversion: the operation is aborted immediately. done never pulses, outputs return to reset values, in_ready = 1.
- Legal range: IN_W >= 1, DIGITS >= 1. Counter width = $clog2(IN_W+1).

Decomposition:
- Package bin2bcd_pkg:
  - state enum {IDLE, CONV, LOAD}.
  - localparam DIGIT_W = 4.
  - localparam BCD_FIX_THRESH = 4'd5.
  - localparam BCD_FIX_ADD = 4'd3.
- Sub-module bcd_add3_digit: 4-bit combinational correction (d >= 5 ? d+3 : d), instantiated DIGITS times in a generate loop.

Test Plan:
- Reset, blank_en = 1, accept in_value = 0 → done pulses 17 cycles after accept, digits = 24'h000000, digit_blank = 6'b111110, overflow = 0.
- Accept 65535 → digits = 24'h065535, digit_blank = 6'b100000, overflow = 0; in_ready low for exactly 17 cycles after the accept edge.
- blank_en = 0, accept 1234 → digits = 24'h001234, digit_blank = 6'b000000. Toggle blank_en = 1 with no new input → digit_blank = 6'b110000 in the same cycle, digits unchanged.
- in_valid held high with in_value = 9, changed to 10 while busy → first result 24'h000009. Second accept occurs 18 cycles after the first, giving 24'h000010. Value changes during busy do not corrupt the first result.
- Accept 40000, assert reset at cycle 5 of CONV → digits = 0, overflow = 0, in_ready = 1 during reset, no done pulse. After release, accept 7 → 24'h000007.
- Override IN_W = 20, DIGITS = 6:
  - Accept 999999 → 24'h999999, overflow = 0.
  - Accept 1000000 → 24'h000000, overflow = 1.
  - Accept 1048575 → 24'h048575, overflow = 1.
